// File: rtl/pixel_gearbox_pkg.sv
// Shared types and constants for the camera-link pixel to DRAM-beat gearbox.
package pixel_gearbox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH,
    SKIP
  } state_e;

  localparam int unsigned DEFAULT_DRAM_DATA_WIDTH = 512;
  localparam int unsigned KEEP_W = DEFAULT_DRAM_DATA_WIDTH / 8;

  function automatic int unsigned keep_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// First-word-fall-through beat queue; a push into a full queue is refused even if a pop happens that cycle.
module beat_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  // Output is forced to zero while empty so reset and idle show a clean bus.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wr_data;
  end

endmodule

// File: rtl/pixel_gearbox.sv
// Packs camera-link pixels LSB-first into wide DRAM beats, with frame framing and sticky status.
module pixel_gearbox
  import pixel_gearbox_pkg::*;
#(
  parameter int unsigned DRAM_DATA_WIDTH = 512,
  parameter int unsigned CHANNELS        = 3,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                         clink_X_clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         fval,
  input  logic                         lval,
  input  logic                         dval,
  input  logic [CHANNELS*8-1:0]        pix,
  output logic [DRAM_DATA_WIDTH-1:0]   m_data,
  output logic [DRAM_DATA_WIDTH/8-1:0] m_keep,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic                         clear_status,
  output logic                         overflow,
  output logic                         gap_err,
  output logic [15:0]                  frame_count,
  output logic [31:0]                  beat_count
);

  localparam int unsigned DW     = DRAM_DATA_WIDTH;
  localparam int unsigned PW     = CHANNELS * 8;
  localparam int unsigned KW     = keep_width(DW);
  localparam int unsigned FILL_W = $clog2(DW + 1);
  localparam int unsigned EXT_W  = DW + PW;
  localparam int unsigned FW     = DW + KW + 1;

  state_e            r_state;
  logic              r_fval;
  logic              r_wait_low;
  logic [DW-1:0]     r_acc;
  logic [FILL_W-1:0] r_fill;
  logic [DW-1:0]     r_pend;
  logic              r_pend_vld;
  logic              r_overflow;
  logic              r_gap_err;
  logic [15:0]       r_frame_cnt;
  logic [31:0]       r_beat_cnt;

  logic              w_pix;
  logic              w_rise;
  logic              w_fall;
  logic              w_accept;
  logic              w_end;
  logic [FILL_W:0]   w_sum;
  logic              w_wrap;
  logic [EXT_W-1:0]  w_ext;
  logic [KW-1:0]     w_flush_keep;
  logic [DW-1:0]     w_flush_data;
  logic              w_push;
  logic              w_push_last;
  logic [KW-1:0]     w_push_keep;
  logic [DW-1:0]     w_push_data;
  logic              w_full;
  logic              w_empty;
  logic [FW-1:0]     w_rd_data;

  assign w_pix    = fval && lval && dval;
  // A frame already running when reset releases must not look like a rising fval.
  assign w_rise   = fval && !r_fval && !r_wait_low;
  assign w_fall   = r_fval && !fval;
  assign w_accept = (r_state == ACTIVE) && w_pix;
  assign w_end    = (r_state == ACTIVE) && w_fall;
  assign w_sum    = {1'b0, r_fill} + (FILL_W+1)'(PW);
  assign w_wrap   = (w_sum >= (FILL_W+1)'(DW));
  // Bits of the pixel landing above DW are the carry-over into the next beat.
  assign w_ext    = EXT_W'(r_acc) | (EXT_W'(pix) << r_fill);

  always_comb begin
    w_flush_keep = '0;
    w_flush_data = '0;
    for (int unsigned i = 0; i < KW; i++) begin
      if (i < 32'(r_fill >> 3)) begin
        w_flush_keep[i]        = 1'b1;
        w_flush_data[i*8 +: 8] = r_acc[i*8 +: 8];
      end
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_keep = '0;
    w_push_data = '0;
    if (r_pend_vld && (w_accept || w_end)) begin
      w_push      = 1'b1;
      w_push_data = r_pend;
      w_push_keep = '1;
      w_push_last = w_end && (r_fill == '0);
    end else if (r_state == FLUSH) begin
      w_push      = 1'b1;
      w_push_data = w_flush_data;
      w_push_keep = w_flush_keep;
      w_push_last = 1'b1;
    end
  end

  always_ff @(posedge clink_X_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fval     <= 1'b0;
      r_wait_low <= 1'b1;
      r_acc      <= '0;
      r_fill     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_fval <= fval;
      if (!fval) r_wait_low <= 1'b0;
      unique case (r_state)
        IDLE: if (w_rise) r_state <= enable ? ACTIVE : SKIP;
        ACTIVE: begin
          if (w_end) begin
            r_pend_vld <= 1'b0;
            r_state    <= (r_fill != '0) ? FLUSH : IDLE;
          end else if (w_accept) begin
            r_pend_vld <= w_wrap;
            if (w_wrap) begin
              r_pend <= w_ext[DW-1:0];
              r_acc  <= DW'(w_ext[DW +: PW]);
              r_fill <= FILL_W'(w_sum - (FILL_W+1)'(DW));
            end else begin
              r_acc  <= w_ext[DW-1:0];
              r_fill <= w_sum[FILL_W-1:0];
            end
          end
        end
        FLUSH: begin
          r_acc   <= '0;
          r_fill  <= '0;
          r_state <= IDLE;
        end
        SKIP: if (w_fall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clink_X_clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_gap_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_beat_cnt  <= '0;
    end else if (clear_status) begin
      r_overflow  <= 1'b0;
      r_gap_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_push && w_full) r_overflow <= 1'b1;
      if (w_push && !w_full) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
        if (w_push_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if ((r_state == FLUSH) && w_pix) r_gap_err <= 1'b1;
    end
  end

  beat_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clink_X_clk),
    .rst       (reset),
    .i_wr_en   (w_push),
    .i_wr_data ({w_push_last, w_push_keep, w_push_data}),
    .i_rd_en   (m_ready),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign {m_last, m_keep, m_data} = w_rd_data;
  assign m_valid     = !w_empty;
  assign overflow    = r_overflow;
  assign gap_err     = r_gap_err;
  assign frame_count = r_frame_cnt;
  assign beat_count  = r_beat_cnt;

endmodule

// File: tb/tb_pixel_gearbox.sv
// Scoreboard bench: a 3-byte and a 4-byte instance share stimulus; a byte-stream model predicts their beats.
module tb_pixel_gearbox;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset, enable, fval, lval, dval, m_ready, clear_status;
  logic [31:0]  pix;

  logic [511:0] m_data3, m_data4;
  logic [63:0]  m_keep3, m_keep4;
  logic         m_last3, m_last4, m_valid3, m_valid4;
  logic         ovf3, ovf4, gap3, gap4;
  logic [15:0]  fcnt3, fcnt4;
  logic [31:0]  bcnt3, bcnt4;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [7:0]  bytes0[$];
  logic [7:0]  bytes1[$];
  int          exp_beats[2];
  int          exp_frames[2];
  logic        exp_ovf[2];
  logic        exp_gap;
  logic        hold;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pixel_gearbox #(.DRAM_DATA_WIDTH(512), .CHANNELS(3), .FIFO_DEPTH(4)) u_dut3 (
    .clink_X_clk(clk), .reset(reset), .enable(enable), .fval(fval), .lval(lval), .dval(dval),
    .pix(pix[23:0]), .m_data(m_data3), .m_keep(m_keep3), .m_last(m_last3), .m_valid(m_valid3),
    .m_ready(m_ready), .clear_status(clear_status), .overflow(ovf3), .gap_err(gap3),
    .frame_count(fcnt3), .beat_count(bcnt3));

  pixel_gearbox #(.DRAM_DATA_WIDTH(512), .CHANNELS(4), .FIFO_DEPTH(4)) u_dut4 (
    .clink_X_clk(clk), .reset(reset), .enable(enable), .fval(fval), .lval(lval), .dval(dval),
    .pix(pix), .m_data(m_data4), .m_keep(m_keep4), .m_last(m_last4), .m_valid(m_valid4),
    .m_ready(m_ready), .clear_status(clear_status), .overflow(ovf4), .gap_err(gap4),
    .frame_count(fcnt4), .beat_count(bcnt4));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input int d, input beat_t b);
    int sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (hold && sz >= 4) exp_ovf[d] = 1'b1;
    else begin
      if (d == 0) q0.push_back(b); else q1.push_back(b);
      exp_beats[d]++;
      if (b.l) exp_frames[d]++;
    end
  endtask

  task automatic emit(input int d, input int n, input logic last);
    beat_t b;
    b = '0;
    for (int j = 0; j < n; j++) begin
      b.d[j*8 +: 8] = (d == 0) ? bytes0.pop_front() : bytes1.pop_front();
      b.k[j] = 1'b1;
    end
    b.l = last;
    model_push(d, b);
  endtask

  task automatic add_pixel(input logic [31:0] px);
    for (int j = 0; j < 3; j++) bytes0.push_back(px[j*8 +: 8]);
    for (int j = 0; j < 4; j++) bytes1.push_back(px[j*8 +: 8]);
    while (bytes0.size() > 64) emit(0, 64, 1'b0);
    while (bytes1.size() > 64) emit(1, 64, 1'b0);
  endtask

  task automatic frame_end();
    if (bytes0.size() > 0) emit(0, bytes0.size(), 1'b1);
    if (bytes1.size() > 0) emit(1, bytes1.size(), 1'b1);
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete(); bytes0.delete(); bytes1.delete();
    exp_beats[0] = 0; exp_beats[1] = 0; exp_frames[0] = 0; exp_frames[1] = 0;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0; exp_gap = 1'b0;
  endtask

  task automatic score(input int d, input logic vld, input logic [511:0] dat,
                       input logic [63:0] kp, input logic lst);
    beat_t b;
    if ((d == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("unexpected_beat%0d", d), vld, 1'b0);
    else begin
      b = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("data%0d", d), dat, b.d);
      chk($sformatf("keep%0d", d), kp, b.k);
      chk($sformatf("last%0d", d), lst, b.l);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid3 && m_ready) score(0, m_valid3, m_data3, m_keep3, m_last3);
    if (m_valid4 && m_ready) score(1, m_valid4, m_data4, m_keep4, m_last4);
  end

  task automatic check_status();
    chk("beat_count3", bcnt3, exp_beats[0]);
    chk("frame_count3", fcnt3, exp_frames[0]);
    chk("overflow3", ovf3, exp_ovf[0]);
    chk("gap_err3", gap3, exp_gap);
    chk("beat_count4", bcnt4, exp_beats[1]);
    chk("frame_count4", fcnt4, exp_frames[1]);
    chk("overflow4", ovf4, exp_ovf[1]);
    chk("gap_err4", gap4, exp_gap);
  endtask

  task automatic clear();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    exp_beats[0] = 0; exp_beats[1] = 0; exp_frames[0] = 0; exp_frames[1] = 0;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0; exp_gap = 1'b0;
  endtask

  // rst_at >= 0 pulses reset just before that pixel; glitch re-raises fval during the flush cycle.
  task automatic frame(input int n, input logic en, input logic glitch, input int rst_at);
    logic [31:0] px;
    enable = en;
    fval   = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        model_clear();
      end
      if (rst_at >= 0 && i == rst_at + 3) reset = 1'b0;
      if (i % 10 == 9) begin
        lval = 1'b1; dval = 1'b0; pix = $urandom;
        tick();
      end
      px = $urandom;
      lval = 1'b1; dval = 1'b1; pix = px;
      if (en && (rst_at < 0 || i < rst_at)) add_pixel(px);
      tick();
    end
    lval = 1'b0; dval = 1'b0;
    tick();
    fval = 1'b0;
    if (en && rst_at < 0) frame_end();
    tick();
    if (glitch) begin
      fval = 1'b1; lval = 1'b1; dval = 1'b1; pix = $urandom;
      exp_gap = 1'b1;
      tick();
      fval = 1'b0; lval = 1'b0; dval = 1'b0;
      tick();
    end
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix = '0;
    m_ready = 1'b1; clear_status = 1'b0; hold = 1'b0;
    model_clear();
    repeat (3) tick();
    chk("rst_valid3", m_valid3, 1'b0);
    chk("rst_data3", m_data3, '0);
    chk("rst_keep3", m_keep3, '0);
    chk("rst_last3", m_last3, 1'b0);
    chk("rst_valid4", m_valid4, 1'b0);
    check_status();
    reset = 1'b0;
    tick();

    frame(64, 1'b1, 1'b0, -1);
    chk("s64_beats3", bcnt3, 32'd3);
    chk("s64_frames3", fcnt3, 16'd1);
    check_status();

    frame(22, 1'b1, 1'b1, -1);
    check_status();

    frame(17, 1'b1, 1'b0, -1);
    check_status();
    clear();
    check_status();

    m_ready = 1'b0;
    hold = 1'b1;
    frame(128, 1'b1, 1'b0, -1);
    chk("ovf_held3", m_valid3, 1'b1);
    chk("ovf_beats3", bcnt3, 32'd4);
    chk("ovf_flag3", ovf3, 1'b1);
    check_status();
    m_ready = 1'b1;
    hold = 1'b0;
    repeat (10) tick();
    clear();
    check_status();

    frame(64, 1'b0, 1'b0, -1);
    check_status();
    frame(64, 1'b1, 1'b0, -1);
    check_status();

    frame(64, 1'b1, 1'b0, 30);
    check_status();
    frame(64, 1'b1, 1'b0, -1);
    chk("post_rst_beats3", bcnt3, 32'd3);
    check_status();

    chk("left0", q0.size(), 0);
    chk("left1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
